// File: rtl/lcd_timing_pkg.sv
// Shared timing types, stock panel timings and field sanitising for the LCD timing generator.
package lcd_timing_pkg;

    localparam int TIM_W = 12;

    typedef logic [TIM_W-1:0] fld_t;

    typedef struct packed {
        fld_t h_act;
        fld_t h_fp;
        fld_t h_sync;
        fld_t h_bp;
        fld_t v_act;
        fld_t v_fp;
        fld_t v_sync;
        fld_t v_bp;
    } timing_t;

    // Sanitised field set plus the totals the counters wrap at.
    typedef struct packed {
        timing_t f;
        fld_t    h_tot;
        fld_t    v_tot;
    } timing_eff_t;

    // Everything that travels alongside de through the read-latency delay.
    typedef struct packed {
        logic hs;
        logic vs;
        logic fs;
        logic ls;
        fld_t x;
        fld_t y;
    } pix_side_t;

    localparam timing_t T_800X480 = '{
        h_act: fld_t'(800), h_fp: fld_t'(40), h_sync: fld_t'(128), h_bp: fld_t'(88),
        v_act: fld_t'(480), v_fp: fld_t'(1),  v_sync: fld_t'(3),   v_bp: fld_t'(21)
    };

    localparam timing_t T_480X272 = '{
        h_act: fld_t'(480), h_fp: fld_t'(2), h_sync: fld_t'(41), h_bp: fld_t'(2),
        v_act: fld_t'(272), v_fp: fld_t'(2), v_sync: fld_t'(10), v_bp: fld_t'(2)
    };

    function automatic fld_t fix_field(fld_t v);
        return (v == '0) ? fld_t'(1) : v;
    endfunction

    function automatic fld_t sat_total(fld_t a, fld_t b, fld_t c, fld_t d);
        logic [TIM_W+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return (s > {2'b00, {TIM_W{1'b1}}}) ? {TIM_W{1'b1}} : s[TIM_W-1:0];
    endfunction

    function automatic timing_eff_t sanitise(timing_t t);
        timing_eff_t e;
        e.f.h_act  = fix_field(t.h_act);
        e.f.h_fp   = fix_field(t.h_fp);
        e.f.h_sync = fix_field(t.h_sync);
        e.f.h_bp   = fix_field(t.h_bp);
        e.f.v_act  = fix_field(t.v_act);
        e.f.v_fp   = fix_field(t.v_fp);
        e.f.v_sync = fix_field(t.v_sync);
        e.f.v_bp   = fix_field(t.v_bp);
        e.h_tot    = sat_total(e.f.h_act, e.f.h_fp, e.f.h_sync, e.f.h_bp);
        e.v_tot    = sat_total(e.f.v_act, e.f.v_fp, e.f.v_sync, e.f.v_bp);
        return e;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_sync_delay.sv
// Delays de and its side-band (sync, start flags, coordinates) by DEPTH cycles; wires through at DEPTH=0.
module lcd_sync_delay
    import lcd_timing_pkg::*;
#(
    parameter int        DEPTH = 1,
    parameter pix_side_t IDLE  = '0
)(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      src_de,
    input  pix_side_t src_pix,
    output logic      dly_de,
    output pix_side_t dly_pix
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dly_de  = src_de;
            assign dly_pix = src_pix;
        end else begin : g_pipe
            logic [DEPTH-1:0]      vld_pipe;
            pix_side_t [DEPTH-1:0] pix_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    for (int i = 0; i < DEPTH; i++) pix_pipe[i] <= IDLE;
                end else begin
                    vld_pipe[0] <= src_de;
                    pix_pipe[0] <= src_pix;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        pix_pipe[i] <= pix_pipe[i-1];
                    end
                end
            end

            assign dly_de  = vld_pipe[DEPTH-1];
            assign dly_pix = pix_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// Runtime-reconfigurable RGB-LCD timing generator; new timing goes live only on a frame boundary.
// CNT_W must equal the package field width TIM_W.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W      = TIM_W,
    parameter int RD_LAT     = 1,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int DEF_H_ACT  = 800,
    parameter int DEF_H_FP   = 40,
    parameter int DEF_H_SYNC = 128,
    parameter int DEF_H_BP   = 88,
    parameter int DEF_V_ACT  = 480,
    parameter int DEF_V_FP   = 1,
    parameter int DEF_V_SYNC = 3,
    parameter int DEF_V_BP   = 21
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    output logic             cfg_applied,
    output logic             pix_req,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] active_x,
    output logic [CNT_W-1:0] active_y,
    output logic             frame_start,
    output logic             line_start
);

    localparam int EW = CNT_W + 2;

    localparam timing_t DEF_T = '{
        h_act: fld_t'(DEF_H_ACT), h_fp: fld_t'(DEF_H_FP), h_sync: fld_t'(DEF_H_SYNC), h_bp: fld_t'(DEF_H_BP),
        v_act: fld_t'(DEF_V_ACT), v_fp: fld_t'(DEF_V_FP), v_sync: fld_t'(DEF_V_SYNC), v_bp: fld_t'(DEF_V_BP)
    };
    localparam timing_eff_t DEF_E = sanitise(DEF_T);

    localparam pix_side_t IDLE = '{hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0, ls: 1'b0, x: '0, y: '0};

    timing_eff_t      live, pend;
    timing_t          cfg_in;
    logic             pend_vld;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_last, v_last, boundary, apply_now;
    logic             h_win, v_win, h_sync, v_sync, req_next;
    logic [EW-1:0]    h_sync_lo, h_sync_hi, v_sync_lo, v_sync_hi;
    logic             s0_de;
    pix_side_t        s0, pix_dly;

    assign cfg_in = '{
        h_act: cfg_h_act, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
        v_act: cfg_v_act, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp
    };

    assign h_last    = (h_cnt == live.h_tot - fld_t'(1));
    assign v_last    = (v_cnt == live.v_tot - fld_t'(1));
    assign boundary  = en && h_last && v_last;
    // Idle counters sit at a frame start, so pending timing can go live at once.
    assign apply_now = boundary || !en;

    // Sync bounds in the wider domain so act+fp+sync cannot wrap.
    assign h_sync_lo = EW'(live.f.h_act) + EW'(live.f.h_fp);
    assign h_sync_hi = h_sync_lo + EW'(live.f.h_sync);
    assign v_sync_lo = EW'(live.f.v_act) + EW'(live.f.v_fp);
    assign v_sync_hi = v_sync_lo + EW'(live.f.v_sync);

    assign h_win    = (h_cnt < live.f.h_act);
    assign v_win    = (v_cnt < live.f.v_act);
    assign h_sync   = (EW'(h_cnt) >= h_sync_lo) && (EW'(h_cnt) < h_sync_hi);
    assign v_sync   = (EW'(v_cnt) >= v_sync_lo) && (EW'(v_cnt) < v_sync_hi);
    assign req_next = en && h_win && v_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + fld_t'(1);
        end else begin
            h_cnt <= h_cnt + fld_t'(1);
        end
    end

    // A strobe on an apply cycle bypasses the pending set entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live        <= DEF_E;
            pend        <= DEF_E;
            pend_vld    <= 1'b0;
            cfg_applied <= 1'b0;
        end else begin
            cfg_applied <= 1'b0;
            if (cfg_valid && apply_now) begin
                live        <= sanitise(cfg_in);
                pend_vld    <= 1'b0;
                cfg_applied <= 1'b1;
            end else if (cfg_valid) begin
                pend     <= sanitise(cfg_in);
                pend_vld <= 1'b1;
            end else if (pend_vld && apply_now) begin
                live        <= pend;
                pend_vld    <= 1'b0;
                cfg_applied <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_de <= 1'b0;
            s0    <= IDLE;
        end else begin
            s0_de <= req_next;
            s0.hs <= (en && h_sync) ? HS_POL : ~HS_POL;
            s0.vs <= (en && v_sync) ? VS_POL : ~VS_POL;
            s0.fs <= req_next && (h_cnt == '0) && (v_cnt == '0);
            s0.ls <= req_next && (h_cnt == '0);
            if (req_next) begin
                s0.x <= h_cnt;
                s0.y <= v_cnt;
            end
        end
    end

    assign pix_req = s0_de;
    assign req_x   = s0.x;
    assign req_y   = s0.y;

    lcd_sync_delay #(
        .DEPTH (RD_LAT),
        .IDLE  (IDLE)
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_de  (s0_de),
        .src_pix (s0),
        .dly_de  (de),
        .dly_pix (pix_dly)
    );

    assign hs          = pix_dly.hs;
    assign vs          = pix_dly.vs;
    assign frame_start = pix_dly.fs;
    assign line_start  = pix_dly.ls;
    assign active_x    = pix_dly.x;
    assign active_y    = pix_dly.y;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: frame-position reference model, directed timing checks and random reconfiguration.
module tb_lcd_timing_gen;

    localparam int W = 12;

    logic         clk, rst_n, en, cfg_valid;
    logic [W-1:0] c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;

    logic         a0_ap, a0_req, a0_hs, a0_vs, a0_de, a0_fs, a0_ls;
    logic [W-1:0] a0_rx, a0_ry, a0_ax, a0_ay;
    logic         a2_ap, a2_req, a2_hs, a2_vs, a2_de, a2_fs, a2_ls;
    logic [W-1:0] a2_rx, a2_ry, a2_ax, a2_ay;

    lcd_timing_gen #(
        .RD_LAT(0), .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(2), .DEF_H_BP(2),
        .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
        .cfg_h_act(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
        .cfg_v_act(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
        .cfg_applied(a0_ap), .pix_req(a0_req), .req_x(a0_rx), .req_y(a0_ry),
        .hs(a0_hs), .vs(a0_vs), .de(a0_de), .active_x(a0_ax), .active_y(a0_ay),
        .frame_start(a0_fs), .line_start(a0_ls)
    );

    lcd_timing_gen #(
        .RD_LAT(2), .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(2), .DEF_H_BP(2),
        .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
        .cfg_h_act(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
        .cfg_v_act(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
        .cfg_applied(a2_ap), .pix_req(a2_req), .req_x(a2_rx), .req_y(a2_ry),
        .hs(a2_hs), .vs(a2_vs), .de(a2_de), .active_x(a2_ax), .active_y(a2_ay),
        .frame_start(a2_fs), .line_start(a2_ls)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, ht, vt;
    } tim_t;

    typedef struct {
        bit req, hs, vs, fs, ls, ap;
        int rx, ry;
    } raw_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   ap_cnt = 0;
    tim_t m_live, m_pend;
    bit   m_pflag;
    int   m_pos, m_lx, m_ly;
    raw_t hist[$];

    function automatic int fixf(int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic tim_t mk_tim(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
        tim_t t;
        t.ha = fixf(ha); t.hf = fixf(hf); t.hs = fixf(hs); t.hb = fixf(hb);
        t.va = fixf(va); t.vf = fixf(vf); t.vs = fixf(vs); t.vb = fixf(vb);
        t.ht = t.ha + t.hf + t.hs + t.hb;
        t.vt = t.va + t.vf + t.vs + t.vb;
        if (t.ht > 4095) t.ht = 4095;
        if (t.vt > 4095) t.vt = 4095;
        return t;
    endfunction

    function automatic raw_t idle_raw();
        raw_t r;
        r.req = 0; r.hs = 1; r.vs = 1; r.fs = 0; r.ls = 0; r.ap = 0; r.rx = 0; r.ry = 0;
        return r;
    endfunction

    function automatic logic [54:0] expv(int n, int lat);
        raw_t p, d;
        p = hist[n];
        d = (n - lat >= 0) ? hist[n - lat] : idle_raw();
        return {p.ap, p.req, W'(p.rx), W'(p.ry), d.req, d.hs, d.vs, W'(d.rx), W'(d.ry), d.fs, d.ls};
    endfunction

    // Frame position is a single index; h and v fall out of div/mod by the line length.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_live  = mk_tim(8, 2, 2, 2, 4, 1, 1, 1);
                m_pend  = m_live;
                m_pflag = 0;
                m_pos   = 0;
                m_lx    = 0;
                m_ly    = 0;
                hist.push_back(idle_raw());
            end else begin
                raw_t e;
                int   h, v;
                bit   bnd, now;
                h = m_pos % m_live.ht;
                v = m_pos / m_live.ht;
                e.req = en && (h < m_live.ha) && (v < m_live.va);
                if (e.req) begin
                    m_lx = h;
                    m_ly = v;
                end
                e.rx = m_lx;
                e.ry = m_ly;
                e.hs = !(en && h >= m_live.ha + m_live.hf && h < m_live.ha + m_live.hf + m_live.hs);
                e.vs = !(en && v >= m_live.va + m_live.vf && v < m_live.va + m_live.vf + m_live.vs);
                e.fs = e.req && h == 0 && v == 0;
                e.ls = e.req && h == 0;
                bnd  = en && (m_pos == m_live.ht * m_live.vt - 1);
                now  = bnd || !en;
                e.ap = 0;
                if (cfg_valid && now) begin
                    m_live  = mk_tim(int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
                                     int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb));
                    m_pflag = 0;
                    e.ap    = 1;
                end else if (cfg_valid) begin
                    m_pend  = mk_tim(int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
                                     int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb));
                    m_pflag = 1;
                end else if (m_pflag && now) begin
                    m_live  = m_pend;
                    m_pflag = 0;
                    e.ap    = 1;
                end
                m_pos = (!en || bnd) ? 0 : m_pos + 1;
                hist.push_back(e);
            end
        end
    end

    task automatic cmpv(string nm, int n, logic [54:0] got, logic [54:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s cycle %0d: got %h expected %h", nm, n, got, exp);
        end
    endtask

    task automatic chk(string nm, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Every cycle out of reset: both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && hist.size() > 0) begin
                int n;
                n = hist.size() - 1;
                cmpv("u0_outputs", n, {a0_ap, a0_req, a0_rx, a0_ry, a0_de, a0_hs, a0_vs,
                                       a0_ax, a0_ay, a0_fs, a0_ls}, expv(n, 0));
                cmpv("u2_outputs", n, {a2_ap, a2_req, a2_rx, a2_ry, a2_de, a2_hs, a2_vs,
                                       a2_ax, a2_ay, a2_fs, a2_ls}, expv(n, 2));
                if (a0_ap) ap_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb);
        c_ha = W'(ha); c_hf = W'(hf); c_hs = W'(hs); c_hb = W'(hb);
        c_va = W'(va); c_vf = W'(vf); c_vs = W'(vs); c_vb = W'(vb);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Measures one frame of u0 from a frame_start up to the next one.
    task automatic measure(output int per, output int des, output int hsl, output int vsl);
        int guard;
        guard = 0;
        per = 0; des = 0; hsl = 0; vsl = 0;
        while (!a0_fs && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (!a0_fs) begin
            chk("measure_start_timeout", 0, 1);
            return;
        end
        do begin
            des += int'(a0_de);
            hsl += int'(!a0_hs);
            vsl += int'(!a0_vs);
            per++;
            @(negedge clk);
        end while (!a0_fs && per < 20000);
    endtask

    initial begin
        int per, des, hsl, vsl, g;
        rst_n = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        c_ha = '0; c_hf = '0; c_hs = '0; c_hb = '0; c_va = '0; c_vf = '0; c_vs = '0; c_vb = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_de", int'(a0_de), 0);
        chk("reset_pix_req", int'(a0_req), 0);
        chk("reset_hs", int'(a0_hs), 1);
        chk("reset_vs", int'(a2_vs), 1);
        chk("reset_active_x", int'(a0_ax), 0);
        chk("reset_cfg_applied", int'(a0_ap), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // 8/2/2/2 x 4/1/1/1 -> 14 x 7
        measure(per, des, hsl, vsl);
        chk("frame_period", per, 98);
        chk("frame_de_count", des, 32);
        chk("frame_hs_low", hsl, 14);
        chk("frame_vs_low", vsl, 14);

        // RD_LAT=2: request leads de by two cycles, x runs 0..7
        chk("lat2_req_at_fs", int'(a2_req), 1);
        chk("lat2_de_before", int'(a2_de), 0);
        repeat (2) @(negedge clk);
        chk("lat2_frame_start", int'(a2_fs), 1);
        for (int i = 0; i < 8; i++) begin
            chk("lat2_active_x", int'(a2_ax), i);
            chk("lat2_de", int'(a2_de), 1);
            @(negedge clk);
        end

        // mid-frame reconfig to 4 px/line
        ap_cnt = 0;
        set_cfg(4, 2, 2, 2, 4, 1, 1, 1);
        measure(per, des, hsl, vsl);
        chk("hact4_period", per, 70);
        chk("hact4_de_count", des, 16);
        chk("hact4_applied_once", ap_cnt, 1);

        // last write wins
        ap_cnt = 0;
        set_cfg(5, 2, 2, 2, 4, 1, 1, 1);
        set_cfg(6, 2, 2, 2, 4, 1, 1, 1);
        measure(per, des, hsl, vsl);
        chk("lastwin_period", per, 84);
        chk("lastwin_de_count", des, 24);
        chk("lastwin_applied_once", ap_cnt, 1);

        // strobe exactly on the boundary cycle
        g = 0;
        while (m_pos != m_live.ht * m_live.vt - 1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("boundary_found", int'(m_pos == m_live.ht * m_live.vt - 1), 1);
        set_cfg(8, 2, 2, 2, 2, 1, 1, 1);
        measure(per, des, hsl, vsl);
        chk("vact2_period", per, 70);
        chk("vact2_de_count", des, 16);

        // zero sync field behaves as 1
        set_cfg(8, 2, 0, 2, 4, 1, 1, 1);
        measure(per, des, hsl, vsl);
        chk("hsync0_period", per, 91);
        chk("hsync0_hs_low", hsl, 7);

        // oversized line saturates at 4095 and hs never fires
        en = 1'b0;
        set_cfg(4000, 100, 1, 1, 1, 1, 1, 1);
        en = 1'b1;
        measure(per, des, hsl, vsl);
        chk("sat_period", per, 16380);
        chk("sat_de_count", des, 4000);
        chk("sat_hs_low", hsl, 0);
        chk("sat_vs_low", vsl, 4095);
        en = 1'b0;
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        en = 1'b1;

        // enable toggle
        repeat (30) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_de_u0", int'(a0_de), 0);
        chk("idle_de_u2", int'(a2_de), 0);
        chk("idle_hs_u2", int'(a2_hs), 1);
        en = 1'b1;
        g = 0;
        while (!a0_de && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("restart_frame_start", int'(a0_fs), 1);
        chk("restart_x", int'(a0_ax), 0);
        chk("restart_y", int'(a0_ay), 0);

        // asynchronous reset mid-line
        g = 0;
        while (!(a0_de && a0_ax == 3) && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_de", int'(a0_de), 0);
        chk("async_rst_req", int'(a0_req), 0);
        chk("async_rst_x", int'(a0_ax), 0);
        chk("async_rst_req_x", int'(a0_rx), 0);
        chk("async_rst_u2_hs", int'(a2_hs), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // random reconfiguration and enable toggling
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) begin
                set_cfg($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2),
                        $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                @(negedge clk);
            end
        end
        en = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
